// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the word-granular memory-copy DMA.
package mem_copy_pkg;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bytes per word and the matching address shift.
  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/mem_copy_dma.sv
// Memory-copy initiator on the single-port data-memory interface.
// Copies len 32-bit words from srcAddr to dstAddr, two cycles per word,
// ascending addresses, with silent wrap at the top of the address space.
// Optional feature macro: MEM_COPY_FILL_EN adds a fill mode that writes a
// latched constant word instead of copying (one cycle per word).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; latches addresses, length (and fill settings)
// READ  | drives source word address, captures readData into the buffer
// WRITE | drives destination word address with memWrite; advances idx
// DONE  | single-cycle completion pulse, then back to IDLE
module mem_copy_dma
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [LEN_W-1:0]  len,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fillData,
`endif
  output logic              busy,
  output logic              done,
  output logic              memWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  // Addresses are held as word addresses so every emitted address is aligned.
  localparam int WA_W = ADDR_W - WORD_SHIFT;

  state_e            state_q, state_d;
  logic [WA_W-1:0]   src_q, src_d;
  logic [WA_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic [LEN_W-1:0]  idx_inc;
  logic              last_word;
  logic [WA_W-1:0]   idx_ext;
  logic [WA_W-1:0]   rd_word;
  logic [WA_W-1:0]   wr_word;
  logic [DATA_W-1:0] wr_src;
  logic              fill_mode;

  // Byte-lane bits of the request addresses carry no meaning for word copies.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{srcAddr[WORD_SHIFT-1:0], dstAddr[WORD_SHIFT-1:0]};

`ifdef MEM_COPY_FILL_EN
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;

  // Fill settings are captured together with the rest of the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Latch fill settings only when a request is accepted.
  always_comb begin
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
    if (state_q == IDLE && start) begin
      fill_d      = fill;
      fill_data_d = fillData;
    end
  end

  assign fill_mode = fill_q;
  assign wr_src    = fill_q ? fill_data_q : buf_q;
`else
  assign fill_mode = 1'b0;
  assign wr_src    = buf_q;
`endif

  // idx never exceeds len-1 while in WRITE, so idx+1 cannot overflow LEN_W.
  assign idx_inc   = idx_q + LEN_W'(1);
  assign last_word = (idx_inc == len_q);
  assign idx_ext   = WA_W'(idx_q);
  assign rd_word   = src_q + idx_ext;
  assign wr_word   = dst_q + idx_ext;

  // State, request registers, index counter and word buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = srcAddr[ADDR_W-1:WORD_SHIFT];
          dst_d = dstAddr[ADDR_W-1:WORD_SHIFT];
          len_d = len;
          idx_d = '0;
          if (len == '0) begin
            state_d = DONE;
          end else if (fill_mode_next()) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        buf_d   = readData;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_inc;
        if (last_word) begin
          state_d = DONE;
        end else if (fill_mode) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fill mode of the request being accepted (taken straight from the port).
  function automatic logic fill_mode_next();
`ifdef MEM_COPY_FILL_EN
    return fill;
`else
    return 1'b0;
`endif
  endfunction

  // Memory-port outputs decoded from the current state; idle bus is all zero.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    memWrite  = 1'b0;
    addr      = '0;
    writeData = '0;
    case (state_q)
      READ: begin
        busy = 1'b1;
        addr = {rd_word, {WORD_SHIFT{1'b0}}};
      end
      WRITE: begin
        busy      = 1'b1;
        memWrite  = 1'b1;
        addr      = {wr_word, {WORD_SHIFT{1'b0}}};
        writeData = wr_src;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: behavioural memory, reference copy
// model feeding an access scoreboard, table of transfers plus hand sequences.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] srcAddr = '0;
  logic [31:0] dstAddr = '0;
  logic [9:0]  len = '0;
  logic        fill = 1'b0;
  logic [31:0] fillData = '0;
  logic        busy, done, memWrite;
  logic [31:0] addr, writeData, readData;

  mem_copy_dma #(.ADDR_W(32), .DATA_W(32), .LEN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .len       (len),
`ifdef MEM_COPY_FILL_EN
    .fill      (fill),
    .fillData  (fillData),
`endif
    .busy      (busy),
    .done      (done),
    .memWrite  (memWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData)
  );

  always #5 clk = ~clk;

  // 4 KB memory image, aliased on addr[11:2]; model uses the same mapping.
  logic [31:0] mem     [0:1023];
  logic [31:0] exp_mem [0:1023];
  logic        tb_we = 1'b0;
  logic [31:0] tb_waddr = '0;
  logic [31:0] tb_wdata = '0;

  assign readData = mem[addr[11:2]];

  always @(posedge clk) begin
    if (memWrite) mem[addr[11:2]] <= writeData;
    else if (tb_we) mem[tb_waddr[11:2]] <= tb_wdata;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } acc_t;
  acc_t sb_q[$];

  // Every bus access by the DUT must match the next expected access.
  always @(negedge clk) begin
    if (!rst && (busy || memWrite)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: unexpected access we=%0b addr=0x%08h at %0t", memWrite, addr, $time);
      end else begin
        acc_t e;
        e = sb_q.pop_front();
        check("sb_we", {31'd0, memWrite}, {31'd0, e.we});
        check("sb_addr", addr, e.a);
        if (e.we) check("sb_wdata", writeData, e.d);
      end
    end
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    exp_mem[a[11:2]] = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Reference copy: forward word loop over the model image.
  task automatic model(input logic [31:0] src, input logic [31:0] dst, input int n,
                       input logic f, input logic [31:0] fd);
    logic [31:0] ra, wa, d;
    for (int k = 0; k < n; k++) begin
      ra = {src[31:2], 2'b00} + 32'(4 * k);
      wa = {dst[31:2], 2'b00} + 32'(4 * k);
      if (f) begin
        d = fd;
      end else begin
        d = exp_mem[ra[11:2]];
        sb_q.push_back('{we: 1'b0, a: ra, d: 32'd0});
      end
      sb_q.push_back('{we: 1'b1, a: wa, d: d});
      exp_mem[wa[11:2]] = d;
    end
  endtask

  task automatic check_image(input string name);
    int diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) diffs++;
    check(name, 32'(diffs), 32'd0);
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [9:0] n,
                          input logic f, input logic [31:0] fd, input bit noisy,
                          input int exp_done, input int exp_busy);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 0;
    model(src, dst, int'(n), f, fd);
    @(negedge clk);
    srcAddr = src; dstAddr = dst; len = n; fill = f; fillData = fd; start = 1'b1;
    @(posedge clk);
    while (!seen && cyc < exp_done + 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        check("done_cycle", 32'(cyc), 32'(exp_done));
        check("done_addr", addr, 32'd0);
        check("done_wdata", writeData, 32'd0);
        check("done_memwrite", {31'd0, memWrite}, 32'd0);
      end
      if (noisy && busy) begin
        start = 1'b1;
        srcAddr = $urandom; dstAddr = $urandom; len = 10'($urandom);
        fill = 1'($urandom); fillData = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles, expected at %0d", cyc, exp_done);
    end
    check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    @(negedge clk);
    start = 1'b0;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    check_image("mem_image");
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [9:0]  n;
    bit          noisy;
    int          exp_done;
    int          exp_busy;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int dcnt;
    vecs[0] = '{src: 32'h100, dst: 32'h200,      n: 10'd4, noisy: 0, exp_done: 9,  exp_busy: 8};
    vecs[1] = '{src: 32'h300, dst: 32'h500,      n: 10'd0, noisy: 0, exp_done: 1,  exp_busy: 0};
    vecs[2] = '{src: 32'h0,   dst: 32'h4,        n: 10'd2, noisy: 0, exp_done: 5,  exp_busy: 4};
    vecs[3] = '{src: 32'h103, dst: 32'hFFFFFFFC, n: 10'd2, noisy: 0, exp_done: 5,  exp_busy: 4};
    vecs[4] = '{src: 32'h600, dst: 32'h700,      n: 10'd7, noisy: 1, exp_done: 15, exp_busy: 14};
    vecs[5] = '{src: 32'h800, dst: 32'h901,      n: 10'd1, noisy: 1, exp_done: 3,  exp_busy: 2};

    // Reset values, held while the memory is preloaded.
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_memwrite", {31'd0, memWrite}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", writeData, 32'd0);

    for (int i = 0; i < 1024; i++) poke(32'(i * 4), 32'hC0DE_0000 | 32'(i));
    for (int k = 0; k < 4; k++) poke(32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
    poke(32'h0, 32'h11);
    poke(32'h4, 32'h22);
    for (int k = 0; k < 5; k++) poke(32'h300 + 32'(4 * k), 32'h3000 + 32'(k));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].n, 1'b0, 32'd0, vecs[v].noisy,
               vecs[v].exp_done, vecs[v].exp_busy);

    for (int k = 0; k < 4; k++) check("basic_dst", mem[128 + k], 32'hA0 + 32'(k));
    check("overlap_w1", mem[1], 32'h11);
    check("overlap_w2", mem[2], 32'h11);
    check("wrap_top", mem[1023], 32'hA0);
    check("wrap_zero", mem[0], 32'hA1);

    // Reset during the WRITE of word 2 of a 5-word copy (cycle T0+6).
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back('{we: 1'b0, a: 32'h300 + 32'(4 * k), d: 32'd0});
      sb_q.push_back('{we: 1'b1, a: 32'h400 + 32'(4 * k), d: exp_mem[(32'h300 >> 2) + k]});
    end
    exp_mem[256] = exp_mem[192];
    exp_mem[257] = exp_mem[193];
    @(negedge clk);
    srcAddr = 32'h300; dstAddr = 32'h400; len = 10'd5; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("rstmid_we_before", {31'd0, memWrite}, 32'd1);
    check("rstmid_addr_before", addr, 32'h408);
    #1 rst = 1'b1;
    #1;
    check("rstmid_we_after", {31'd0, memWrite}, 32'd0);
    check("rstmid_busy_after", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("rstmid_no_done", 32'(dcnt), 32'd0);
    check("rstmid_sb_drain", 32'(sb_q.size()), 32'd0);
    check("rstmid_w0", mem[256], 32'h3000);
    check("rstmid_w1", mem[257], 32'h3001);
    check("rstmid_w2_untouched", mem[258], 32'hC0DE_0000 | 32'd258);
    check("rstmid_w4_untouched", mem[260], 32'hC0DE_0000 | 32'd260);
    check_image("rstmid_image");

    run_xfer(32'hA00, 32'hB00, 10'd3, 1'b0, 32'd0, 1'b0, 7, 6);

`ifdef MEM_COPY_FILL_EN
    run_xfer(32'h0, 32'h40, 10'd3, 1'b1, 32'hDEADBEEF, 1'b1, 4, 3);
    for (int k = 0; k < 3; k++) check("fill_dst", mem[16 + k], 32'hDEADBEEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
